// File: rtl/oq_regs_eval_full_hyst_pkg.sv
// Shared constants and helpers for the output-queue full-flag evaluator.
package oq_regs_eval_full_hyst_pkg;

  // Ceiling log2; used only in constant expressions.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int SRAM_ADDR_WIDTH   = 19;
  localparam int CTRL_WIDTH        = 8;
  localparam int NUM_OUTPUT_QUEUES = 8;
  localparam int NUM_OQ_WIDTH      = log2(NUM_OUTPUT_QUEUES);
  localparam int MAX_PKT           = 2048 / CTRL_WIDTH;
  // Smallest packet in words: 60-byte minimum frame plus the module header word.
  localparam int MIN_PKT           = 60 / CTRL_WIDTH + 1;
  // Enough bits to count a RAM full of minimum-size packets, plus one.
  localparam int PKTS_IN_RAM_WIDTH = log2((2 ** SRAM_ADDR_WIDTH) / MIN_PKT) + 1;
  localparam int HYST_PKTS         = 2;
  localparam int HYST_WORDS        = 64;

endpackage

// File: rtl/oq_regs_eval_full_hyst_hyst_eval.sv
// Combinational hysteresis comparator for one flag field (packets or words).
// All arithmetic is one bit wider than the operands so the hysteresis add never wraps.
module oq_hyst_eval #(
  parameter int WIDTH    = 17,
  parameter int HYST     = 2,
  parameter bit IS_WORDS = 1'b0,
  parameter int MIN_LEFT = 0
) (
  input  logic             flag_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             result_o
);

  localparam logic [WIDTH:0] HYST_X = (WIDTH + 1)'(HYST);

  logic [WIDTH:0] value_x;
  logic [WIDTH:0] limit_x;

  assign value_x = {1'b0, value_i};
  assign limit_x = {1'b0, limit_i};

  if (IS_WORDS) begin : g_words
    localparam logic [WIDTH:0] MIN_X = (WIDTH + 1)'(MIN_LEFT);
    localparam logic [WIDTH:0] MIN_H = (WIDTH + 1)'(MIN_LEFT + HYST);
    logic [WIDTH:0] limit_h;
    assign limit_h = limit_x + HYST_X;

    // Set on low space; once set, release only with margin above both limits.
    always_comb begin
      result_o = 1'b0;
      if (!flag_i) result_o = (value_x <= limit_x) || (value_x < MIN_X);
      else         result_o = !((value_x > limit_h) && (value_x >= MIN_H));
    end
  end else begin : g_pkts
    logic [WIDTH:0] value_h;
    assign value_h = value_x + HYST_X;

    // A zero limit disables the criterion; otherwise set at limit, release below limit-HYST.
    always_comb begin
      result_o = 1'b0;
      if (limit_x != '0) begin
        if (!flag_i) result_o = value_x >= limit_x;
        else         result_o = value_h >= limit_x;
      end
    end
  end

endmodule

// File: rtl/oq_regs_eval_full_hyst.sv
// Per-queue full flags with hysteresis. Each queue has a packet-count flag and a
// words-left flag; full is their OR. Colliding src results and initialize requests
// are held one deep and applied when their field has no higher-priority write.
//
// Strobe semantics: *_done is a single-cycle valid with no ready; the value beside it
// is only meaningful in that cycle. *_update starts a register read whose oq is taken
// the same cycle and whose max/thresh data is taken the following cycle.
module oq_regs_eval_full_hyst
  import oq_regs_eval_full_hyst_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dst_update,
  input  logic [NUM_OQ_WIDTH-1:0]      dst_oq,
  input  logic [PKTS_IN_RAM_WIDTH-1:0] dst_max_pkts_in_q,
  input  logic [SRAM_ADDR_WIDTH-1:0]   dst_oq_full_thresh,
  input  logic [PKTS_IN_RAM_WIDTH-1:0] dst_num_pkts_in_q,
  input  logic [SRAM_ADDR_WIDTH-1:0]   dst_num_words_left,
  input  logic                         dst_num_pkts_in_q_done,
  input  logic                         dst_num_words_left_done,
  input  logic                         src_update,
  input  logic [NUM_OQ_WIDTH-1:0]      src_oq,
  input  logic [PKTS_IN_RAM_WIDTH-1:0] src_max_pkts_in_q,
  input  logic [SRAM_ADDR_WIDTH-1:0]   src_oq_full_thresh,
  input  logic [PKTS_IN_RAM_WIDTH-1:0] src_num_pkts_in_q,
  input  logic [SRAM_ADDR_WIDTH-1:0]   src_num_words_left,
  input  logic                         src_num_pkts_in_q_done,
  input  logic                         src_num_words_left_done,
  input  logic                         initialize,
  input  logic [NUM_OQ_WIDTH-1:0]      initialize_oq,
  output logic [NUM_OUTPUT_QUEUES-1:0] full,
  output logic [NUM_OUTPUT_QUEUES-1:0] full_rise
);

  localparam int NQ = NUM_OUTPUT_QUEUES;
  localparam int QW = NUM_OQ_WIDTH;
  localparam int PW = PKTS_IN_RAM_WIDTH;
  localparam int AW = SRAM_ADDR_WIDTH;

  // Latched register-read results per side.
  logic          dst_upd_d1_q, src_upd_d1_q;
  logic [QW-1:0] dst_oq_q, src_oq_q;
  logic [PW-1:0] dst_max_q, src_max_q;
  logic [AW-1:0] dst_thresh_q, src_thresh_q;

  // Flag fields.
  logic [NQ-1:0] pkts_q, words_q;

  // Held src results (carry their own oq and limit so a later src_update cannot disturb them).
  logic          hsp_vld_q, hsw_vld_q;
  logic [QW-1:0] hsp_oq_q, hsw_oq_q;
  logic [PW-1:0] hsp_val_q, hsp_lim_q;
  logic [AW-1:0] hsw_val_q, hsw_lim_q;

  // Held initialize requests, one per field.
  logic          ip_vld_q, iw_vld_q;
  logic [QW-1:0] ip_oq_q, iw_oq_q;

  logic [NQ-1:0] full_q, full_d1_q, full_rise_q;

  // src comparator inputs: the live src result, or the held one when no src result is present.
  logic          sp_use_held, sw_use_held;
  logic [QW-1:0] sp_oq, sw_oq;
  logic [PW-1:0] sp_val, sp_lim;
  logic [AW-1:0] sw_val, sw_lim;
  logic          dst_p_res, dst_w_res, src_p_res, src_w_res;

  assign sp_use_held = !src_num_pkts_in_q_done;
  assign sw_use_held = !src_num_words_left_done;
  assign sp_oq  = sp_use_held ? hsp_oq_q  : src_oq_q;
  assign sp_val = sp_use_held ? hsp_val_q : src_num_pkts_in_q;
  assign sp_lim = sp_use_held ? hsp_lim_q : src_max_q;
  assign sw_oq  = sw_use_held ? hsw_oq_q  : src_oq_q;
  assign sw_val = sw_use_held ? hsw_val_q : src_num_words_left;
  assign sw_lim = sw_use_held ? hsw_lim_q : src_thresh_q;

  oq_hyst_eval #(.WIDTH(PW), .HYST(HYST_PKTS), .IS_WORDS(1'b0), .MIN_LEFT(0)) u_dst_pkts (
    .flag_i(pkts_q[dst_oq_q]), .value_i(dst_num_pkts_in_q), .limit_i(dst_max_q), .result_o(dst_p_res));
  oq_hyst_eval #(.WIDTH(AW), .HYST(HYST_WORDS), .IS_WORDS(1'b1), .MIN_LEFT(2 * MAX_PKT)) u_dst_words (
    .flag_i(words_q[dst_oq_q]), .value_i(dst_num_words_left), .limit_i(dst_thresh_q), .result_o(dst_w_res));
  oq_hyst_eval #(.WIDTH(PW), .HYST(HYST_PKTS), .IS_WORDS(1'b0), .MIN_LEFT(0)) u_src_pkts (
    .flag_i(pkts_q[sp_oq]), .value_i(sp_val), .limit_i(sp_lim), .result_o(src_p_res));
  oq_hyst_eval #(.WIDTH(AW), .HYST(HYST_WORDS), .IS_WORDS(1'b1), .MIN_LEFT(2 * MAX_PKT)) u_src_words (
    .flag_i(words_q[sw_oq]), .value_i(sw_val), .limit_i(sw_lim), .result_o(src_w_res));

  // Capture oq on update and the max/thresh read data one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_upd_d1_q <= 1'b0; dst_oq_q <= '0; dst_max_q <= '0; dst_thresh_q <= '0;
      src_upd_d1_q <= 1'b0; src_oq_q <= '0; src_max_q <= '0; src_thresh_q <= '0;
    end else begin
      dst_upd_d1_q <= dst_update;
      src_upd_d1_q <= src_update;
      if (dst_update) dst_oq_q <= dst_oq;
      if (src_update) src_oq_q <= src_oq;
      if (dst_upd_d1_q) begin
        dst_max_q    <= dst_max_pkts_in_q;
        dst_thresh_q <= dst_oq_full_thresh;
      end
      if (src_upd_d1_q) begin
        src_max_q    <= src_max_pkts_in_q;
        src_thresh_q <= src_oq_full_thresh;
      end
    end
  end

  // Packet-count field: dst > src > held src > held init.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkts_q <= '0; hsp_vld_q <= 1'b0; hsp_oq_q <= '0; hsp_val_q <= '0; hsp_lim_q <= '0;
      ip_vld_q <= 1'b0; ip_oq_q <= '0;
    end else begin
      if (dst_num_pkts_in_q_done) begin
        pkts_q[dst_oq_q] <= dst_p_res;
        if (src_num_pkts_in_q_done) begin
          hsp_vld_q <= 1'b1;
          hsp_oq_q  <= src_oq_q;
          hsp_val_q <= src_num_pkts_in_q;
          hsp_lim_q <= src_max_q;
        end
      end else if (src_num_pkts_in_q_done) begin
        pkts_q[sp_oq] <= src_p_res;
      end else if (hsp_vld_q) begin
        pkts_q[sp_oq] <= src_p_res;
        hsp_vld_q     <= 1'b0;
      end else if (ip_vld_q) begin
        pkts_q[ip_oq_q] <= 1'b0;
        ip_vld_q        <= 1'b0;
      end
      if (initialize) begin
        ip_vld_q <= 1'b1;
        ip_oq_q  <= initialize_oq;
      end
    end
  end

  // Words-left field: same priority order as the packet-count field.
  always_ff @(posedge clk) begin
    if (reset) begin
      words_q <= '0; hsw_vld_q <= 1'b0; hsw_oq_q <= '0; hsw_val_q <= '0; hsw_lim_q <= '0;
      iw_vld_q <= 1'b0; iw_oq_q <= '0;
    end else begin
      if (dst_num_words_left_done) begin
        words_q[dst_oq_q] <= dst_w_res;
        if (src_num_words_left_done) begin
          hsw_vld_q <= 1'b1;
          hsw_oq_q  <= src_oq_q;
          hsw_val_q <= src_num_words_left;
          hsw_lim_q <= src_thresh_q;
        end
      end else if (src_num_words_left_done) begin
        words_q[sw_oq] <= src_w_res;
      end else if (hsw_vld_q) begin
        words_q[sw_oq] <= src_w_res;
        hsw_vld_q      <= 1'b0;
      end else if (iw_vld_q) begin
        words_q[iw_oq_q] <= 1'b0;
        iw_vld_q         <= 1'b0;
      end
      if (initialize) begin
        iw_vld_q <= 1'b1;
        iw_oq_q  <= initialize_oq;
      end
    end
  end

  // Registered full vector and its rising-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= '0; full_d1_q <= '0; full_rise_q <= '0;
    end else begin
      full_q      <= pkts_q | words_q;
      full_d1_q   <= full_q;
      full_rise_q <= full_q & ~full_d1_q;
    end
  end

  assign full      = full_q;
  assign full_rise = full_rise_q;

endmodule

// File: tb/tb_oq_regs_eval_full_hyst.sv
// Bench for oq_regs_eval_full_hyst: directed scenarios followed by a randomized phase,
// every cycle compared against a behavioural model of the flag rules.
module tb_oq_regs_eval_full_hyst;
  import oq_regs_eval_full_hyst_pkg::*;

  localparam int NQ = NUM_OUTPUT_QUEUES;
  typedef logic [NUM_OQ_WIDTH-1:0]      qidx_t;
  typedef logic [PKTS_IN_RAM_WIDTH-1:0] pcnt_t;
  typedef logic [SRAM_ADDR_WIDTH-1:0]   wcnt_t;
  typedef struct { int oq; longint val; longint lim; } ev_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic dst_update = 0, src_update = 0, initialize = 0;
  qidx_t dst_oq = '0, src_oq = '0, initialize_oq = '0;
  pcnt_t dst_max_pkts_in_q = '0, src_max_pkts_in_q = '0, dst_num_pkts_in_q = '0, src_num_pkts_in_q = '0;
  wcnt_t dst_oq_full_thresh = '0, src_oq_full_thresh = '0, dst_num_words_left = '0, src_num_words_left = '0;
  logic dst_num_pkts_in_q_done = 0, dst_num_words_left_done = 0;
  logic src_num_pkts_in_q_done = 0, src_num_words_left_done = 0;
  logic [NQ-1:0] full, full_rise;

  oq_regs_eval_full_hyst dut (
    .clk(clk), .reset(reset),
    .dst_update(dst_update), .dst_oq(dst_oq), .dst_max_pkts_in_q(dst_max_pkts_in_q),
    .dst_oq_full_thresh(dst_oq_full_thresh), .dst_num_pkts_in_q(dst_num_pkts_in_q),
    .dst_num_words_left(dst_num_words_left), .dst_num_pkts_in_q_done(dst_num_pkts_in_q_done),
    .dst_num_words_left_done(dst_num_words_left_done),
    .src_update(src_update), .src_oq(src_oq), .src_max_pkts_in_q(src_max_pkts_in_q),
    .src_oq_full_thresh(src_oq_full_thresh), .src_num_pkts_in_q(src_num_pkts_in_q),
    .src_num_words_left(src_num_words_left), .src_num_pkts_in_q_done(src_num_pkts_in_q_done),
    .src_num_words_left_done(src_num_words_left_done),
    .initialize(initialize), .initialize_oq(initialize_oq),
    .full(full), .full_rise(full_rise)
  );

  int n_checks = 0;
  int n_pass = 0;

  // reference model state
  bit m_pk[NQ];
  bit m_wd[NQ];
  logic [NQ-1:0] e_full = '0, e_full_d1 = '0, e_rise = '0;
  int m_d_oq = 0, m_s_oq = 0;
  longint m_d_max = 0, m_d_thr = 0, m_s_max = 0, m_s_thr = 0;
  bit m_d_cap = 0, m_s_cap = 0;
  ev_t hp_q[$];
  ev_t hw_q[$];
  bit ip_v = 0, iw_v = 0;
  int ip_oq = 0, iw_oq = 0;

  function automatic bit ref_pkts(bit f, longint num, longint mx);
    if (mx == 0) return 1'b0;
    if (!f) return num >= mx;
    return !(num + HYST_PKTS < mx);
  endfunction

  function automatic bit ref_words(bit f, longint left, longint th);
    if (!f) return (left <= th) || (left < 2 * MAX_PKT);
    return !((left > th + HYST_WORDS) && (left >= 2 * MAX_PKT + HYST_WORDS));
  endfunction

  task automatic chk(input string tag, input logic [NQ-1:0] obs, input logic [NQ-1:0] req);
    n_checks++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, req);
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    ev_t e;
    e_rise    = e_full & ~e_full_d1;
    e_full_d1 = e_full;
    for (int q = 0; q < NQ; q++) e_full[q] = m_pk[q] | m_wd[q];
    if (reset) begin
      e_full = '0; e_full_d1 = '0; e_rise = '0;
      for (int q = 0; q < NQ; q++) begin m_pk[q] = 0; m_wd[q] = 0; end
      hp_q.delete(); hw_q.delete();
      ip_v = 0; iw_v = 0; ip_oq = 0; iw_oq = 0;
      m_d_oq = 0; m_s_oq = 0; m_d_max = 0; m_d_thr = 0; m_s_max = 0; m_s_thr = 0;
      m_d_cap = 0; m_s_cap = 0;
      return;
    end
    if (src_num_pkts_in_q_done) begin
      n_checks++;
      assert (hp_q.size() == 0) n_pass++;
      else $error("FAIL src_pkts_done_while_held: held=%0d required=0", hp_q.size());
    end
    if (src_num_words_left_done) begin
      n_checks++;
      assert (hw_q.size() == 0) n_pass++;
      else $error("FAIL src_words_done_while_held: held=%0d required=0", hw_q.size());
    end
    if (dst_num_pkts_in_q_done) begin
      m_pk[m_d_oq] = ref_pkts(m_pk[m_d_oq], longint'(dst_num_pkts_in_q), m_d_max);
      if (src_num_pkts_in_q_done) hp_q.push_back('{m_s_oq, longint'(src_num_pkts_in_q), m_s_max});
    end else if (src_num_pkts_in_q_done) begin
      m_pk[m_s_oq] = ref_pkts(m_pk[m_s_oq], longint'(src_num_pkts_in_q), m_s_max);
    end else if (hp_q.size() > 0) begin
      e = hp_q.pop_front();
      m_pk[e.oq] = ref_pkts(m_pk[e.oq], e.val, e.lim);
    end else if (ip_v) begin
      m_pk[ip_oq] = 0;
      ip_v = 0;
    end
    if (dst_num_words_left_done) begin
      m_wd[m_d_oq] = ref_words(m_wd[m_d_oq], longint'(dst_num_words_left), m_d_thr);
      if (src_num_words_left_done) hw_q.push_back('{m_s_oq, longint'(src_num_words_left), m_s_thr});
    end else if (src_num_words_left_done) begin
      m_wd[m_s_oq] = ref_words(m_wd[m_s_oq], longint'(src_num_words_left), m_s_thr);
    end else if (hw_q.size() > 0) begin
      e = hw_q.pop_front();
      m_wd[e.oq] = ref_words(m_wd[e.oq], e.val, e.lim);
    end else if (iw_v) begin
      m_wd[iw_oq] = 0;
      iw_v = 0;
    end
    if (initialize) begin
      ip_v = 1; iw_v = 1;
      ip_oq = int'(initialize_oq); iw_oq = int'(initialize_oq);
    end
    if (m_d_cap) begin m_d_max = longint'(dst_max_pkts_in_q); m_d_thr = longint'(dst_oq_full_thresh); end
    if (m_s_cap) begin m_s_max = longint'(src_max_pkts_in_q); m_s_thr = longint'(src_oq_full_thresh); end
    m_d_cap = dst_update;
    m_s_cap = src_update;
    if (dst_update) m_d_oq = int'(dst_oq);
    if (src_update) m_s_oq = int'(src_oq);
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later, strobes dropped.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("full", full, e_full);
    chk("full_rise", full_rise, e_rise);
    dst_update = 0; src_update = 0; initialize = 0;
    dst_num_pkts_in_q_done = 0; dst_num_words_left_done = 0;
    src_num_pkts_in_q_done = 0; src_num_words_left_done = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic dst_txn(input qidx_t oq, input pcnt_t mx, input wcnt_t th,
                         input bit dp, input pcnt_t num, input bit dw, input wcnt_t left);
    dst_update = 1; dst_oq = oq; dst_max_pkts_in_q = mx; dst_oq_full_thresh = th;
    tick(); tick();
    dst_num_pkts_in_q = num; dst_num_pkts_in_q_done = dp;
    dst_num_words_left = left; dst_num_words_left_done = dw;
    tick();
  endtask

  task automatic src_txn(input qidx_t oq, input pcnt_t mx, input wcnt_t th,
                         input bit dp, input pcnt_t num, input bit dw, input wcnt_t left);
    src_update = 1; src_oq = oq; src_max_pkts_in_q = mx; src_oq_full_thresh = th;
    tick(); tick();
    src_num_pkts_in_q = num; src_num_pkts_in_q_done = dp;
    src_num_words_left = left; src_num_words_left_done = dw;
    tick();
  endtask

  initial begin
    int d_st, d_age, s_st, s_age;
    bit d_pp, d_wp, s_pp, s_wp;

    do_reset();
    chk("reset_full", full, 8'h00);
    chk("reset_full_rise", full_rise, 8'h00);

    // packet-count hysteresis on q3
    dst_txn(3'd3, 10, 0, 1, 10, 0, 0);
    tick(); chk("t1_set_full", full, 8'h08);
    tick(); chk("t1_rise", full_rise, 8'h08);
    src_txn(3'd3, 10, 0, 1, 9, 0, 0);
    idle(2); chk("t1_hold_at_9", full, 8'h08);
    src_txn(3'd3, 10, 0, 1, 7, 0, 0);
    idle(2); chk("t1_clear_at_7", full, 8'h00);

    // words-left hysteresis on q0
    do_reset();
    dst_txn(3'd0, 0, 1000, 0, 0, 1, 1000);
    idle(2); chk("t2_set_1000", full, 8'h01);
    dst_txn(3'd0, 0, 1000, 0, 0, 1, 1050);
    idle(2); chk("t2_hold_1050", full, 8'h01);
    dst_txn(3'd0, 0, 1000, 0, 0, 1, 1064);
    idle(2); chk("t2_hold_1064", full, 8'h01);
    dst_txn(3'd0, 0, 1000, 0, 0, 1, 1065);
    idle(2); chk("t2_clear_1065", full, 8'h00);
    dst_txn(3'd0, 0, 0, 0, 0, 1, 511);
    idle(2); chk("t2_min_space", full, 8'h01);
    dst_txn(3'd6, 0, 0, 1, 5, 0, 0);
    idle(2); chk("t2_max_zero_disabled", full, 8'h01);

    // collision: dst on q1, src on q5 in the same cycle, then another dst on q1
    do_reset();
    dst_txn(3'd5, 10, 0, 1, 12, 0, 0);
    idle(2); chk("t3_pre", full, 8'h20);
    dst_update = 1; dst_oq = 3'd1; dst_max_pkts_in_q = 10;
    src_update = 1; src_oq = 3'd5; src_max_pkts_in_q = 10;
    tick(); tick();
    dst_num_pkts_in_q = 10; dst_num_pkts_in_q_done = 1;
    src_num_pkts_in_q = 2;  src_num_pkts_in_q_done = 1;
    tick();
    dst_num_pkts_in_q = 10; dst_num_pkts_in_q_done = 1;
    tick();
    tick(); chk("t3_held_delayed", full, 8'h22);
    tick(); chk("t3_held_applied", full, 8'h02);

    // same queue: dst sets and src clears together
    do_reset();
    dst_update = 1; dst_oq = 3'd2; dst_max_pkts_in_q = 10;
    src_update = 1; src_oq = 3'd2; src_max_pkts_in_q = 10;
    tick(); tick();
    dst_num_pkts_in_q = 10; dst_num_pkts_in_q_done = 1;
    src_num_pkts_in_q = 3;  src_num_pkts_in_q_done = 1;
    tick();
    tick(); chk("t4_one_cycle_full", full, 8'h04);
    chk("t4_rise_pending", full_rise, 8'h00);
    tick(); chk("t4_cleared", full, 8'h00);
    chk("t4_rise", full_rise, 8'h04);

    // initialize held behind a dst stream
    do_reset();
    dst_txn(3'd4, 10, 0, 1, 10, 0, 0);
    dst_txn(3'd6, 10, 0, 1, 10, 0, 0);
    idle(2); chk("t5_pre", full, 8'h50);
    dst_update = 1; dst_oq = 3'd6; dst_max_pkts_in_q = 10; dst_oq_full_thresh = 0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      dst_num_pkts_in_q = 12; dst_num_pkts_in_q_done = 1;
      dst_num_words_left = 100000; dst_num_words_left_done = 1;
      if (i == 0) begin initialize = 1; initialize_oq = 3'd4; end
      tick();
    end
    tick(); chk("t5_init_waits", full, 8'h50);
    tick(); chk("t5_init_applied", full, 8'h40);

    // reset with held src and held init pending
    do_reset();
    dst_update = 1; dst_oq = 3'd1; dst_max_pkts_in_q = 10;
    src_update = 1; src_oq = 3'd7; src_max_pkts_in_q = 10;
    tick(); tick();
    dst_num_pkts_in_q = 10; dst_num_pkts_in_q_done = 1;
    src_num_pkts_in_q = 11; src_num_pkts_in_q_done = 1;
    initialize = 1; initialize_oq = 3'd1;
    tick();
    reset = 1; dst_num_pkts_in_q = 10; dst_num_pkts_in_q_done = 1;
    tick();
    reset = 0;
    chk("t6_full_after_reset", full, 8'h00);
    chk("t6_rise_after_reset", full_rise, 8'h00);
    idle(4); chk("t6_nothing_deferred", full, 8'h00);

    // randomized traffic on both sides with occasional initialize
    do_reset();
    d_st = 0; d_age = 0; s_st = 0; s_age = 0;
    d_pp = 0; d_wp = 0; s_pp = 0; s_wp = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (d_st == 0) begin
        if ($urandom_range(0, 2) == 0) begin
          dst_update = 1; dst_oq = qidx_t'($urandom_range(0, NQ - 1));
          dst_max_pkts_in_q = pcnt_t'($urandom_range(0, 12));
          dst_oq_full_thresh = wcnt_t'($urandom_range(300, 1100));
          d_st = 1; d_age = 0; d_pp = 1; d_wp = 1;
        end
      end else begin
        d_age++;
        if (d_age >= 2) begin
          if (d_pp && $urandom_range(0, 1) == 1) begin
            dst_num_pkts_in_q = pcnt_t'($urandom_range(0, 15)); dst_num_pkts_in_q_done = 1; d_pp = 0;
          end
          if (d_wp && $urandom_range(0, 1) == 1) begin
            dst_num_words_left = wcnt_t'($urandom_range(300, 1300)); dst_num_words_left_done = 1; d_wp = 0;
          end
          if (!d_pp && !d_wp) d_st = 0;
        end
      end
      if (s_st == 0) begin
        if ($urandom_range(0, 2) == 0) begin
          src_update = 1; src_oq = qidx_t'($urandom_range(0, NQ - 1));
          src_max_pkts_in_q = pcnt_t'($urandom_range(0, 12));
          src_oq_full_thresh = wcnt_t'($urandom_range(300, 1100));
          s_st = 1; s_age = 0; s_pp = 1; s_wp = 1;
        end
      end else begin
        s_age++;
        if (s_age >= 2) begin
          if (s_pp && hp_q.size() == 0 && $urandom_range(0, 1) == 1) begin
            src_num_pkts_in_q = pcnt_t'($urandom_range(0, 15)); src_num_pkts_in_q_done = 1; s_pp = 0;
          end
          if (s_wp && hw_q.size() == 0 && $urandom_range(0, 1) == 1) begin
            src_num_words_left = wcnt_t'($urandom_range(300, 1300)); src_num_words_left_done = 1; s_wp = 0;
          end
          if (!s_pp && !s_wp) s_st = 0;
        end
      end
      if ($urandom_range(0, 15) == 0) begin
        initialize = 1; initialize_oq = qidx_t'($urandom_range(0, NQ - 1));
      end
      tick();
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/oq_regs_eval_full_hyst.md
Name: oq_regs_eval_full_hyst

Overview:
Per-queue full-flag evaluator for the SRAM output queues, sitting between the OQ register file and the input arbiter.
- Successor to the single-threshold evaluator; generalised in queue count and widths.
- Adds programmable hysteresis on both the packet-count and words-left criteria, so flags do not chatter at the boundary.
- Adds lossless one-deep holding of colliding source and initialize events, plus a registered full-rise pulse vector for the stats counters.

Parameters:
SRAM_ADDR_WIDTH, 19, width of word counts and thresholds
CTRL_WIDTH, 8, bytes per word
NUM_OUTPUT_QUEUES, 8, number of queues
NUM_OQ_WIDTH, log2(NUM_OUTPUT_QUEUES), queue index width
MAX_PKT, 2048/CTRL_WIDTH, largest packet in words
PKTS_IN_RAM_WIDTH, 17, packet-count width
HYST_PKTS, 2, packet-count hysteresis (packets)
HYST_WORDS, 64, words-left hysteresis (words)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high
dst_update  in  1  store-side register read issued for dst_oq
dst_oq  in  NUM_OQ_WIDTH  queue being stored to
dst_max_pkts_in_q  in  PKTS_IN_RAM_WIDTH  read data, valid the cycle after dst_update
dst_oq_full_thresh  in  SRAM_ADDR_WIDTH  read data, valid the cycle after dst_update
dst_num_pkts_in_q / dst_num_words_left  in  PKTS_IN_RAM_WIDTH / SRAM_ADDR_WIDTH  updated values
dst_num_pkts_in_q_done / dst_num_words_left_done  in  1  strobes: value valid this cycle
src_*  in  (same set as dst_*)  remove side
initialize  in  1  clear both flags of initialize_oq
initialize_oq  in  NUM_OQ_WIDTH  queue to clear
full  out  NUM_OUTPUT_QUEUES  full_pkts | full_words, one bit per queue
full_rise  out  NUM_OUTPUT_QUEUES  one-cycle pulse per 0->1 transition of full

Behaviour:
Capture timing
- dst_update/src_update at cycle t: latch oq at t; latch max_pkts and full_thresh at t+1.
- done strobes arrive no earlier than t+2.
- A new update for a side does not arrive before that side's done strobes.

Two independent flag fields per queue, pkts and words. Evaluation uses the queue's current flag F.
- pkts, with max == 0: result is 0, criterion disabled.
- pkts, F == 0: set when num >= max.
- pkts, F == 1: clear only when num + HYST_PKTS < max; otherwise hold 1. Compute in PKTS_IN_RAM_WIDTH+1 bits, no wrap.
- words, F == 0: set when left <= thresh OR left < 2*MAX_PKT.
- words, F == 1: clear only when left > thresh + HYST_WORDS AND left >= 2*MAX_PKT + HYST_WORDS; otherwise hold 1. Compute in SRAM_ADDR_WIDTH+1 bits.

Per-field write priority each cycle: dst done > src done > held src > held init.
- dst and src done in the same cycle: src's raw value goes into a one-deep held register (value + held-valid). Its oq and thresholds are already latched.
- Held src is evaluated at apply time against the then-current flag, not at capture.
- Held src persists across further dst-done cycles until applied; it is never overwritten or dropped.
- Upstream guarantees no new src done while held src is valid. The bench checks this with an assertion.
- Same queue written by dst then held src: final state is src's result, one cycle later.

Initialize
- Sets held-init (queue index + valid) per field.
- Applied when the field has no higher-priority write; on apply, that field's flag for initialize_oq goes to 0.
- A second initialize while held-init is pending overwrites the pending queue index.

full and full_rise timing
- full is the OR of the registered field flags; it changes the cycle after the write is applied.
- full_rise = full & ~full_d1, registered; it pulses one cycle after the full rise.

Reset (synchronous)
- Clears: flags, full, full_rise, full_d1, held valids, latched oq/max/thresh (all 0).
- Reset mid-operation: pending held events are discarded.
- After reset, the first evaluation uses F = 0.

Decomposition:
- Shared include: log2 function, MIN_PKT, PKTS_IN_RAM_WIDTH derivation.
- Sub-module oq_hyst_eval: combinational hysteresis comparator, parameterised on width and hysteresis.
- oq_hyst_eval is instantiated for dst-pkts, dst-words, src-pkts and src-words. The held-src evaluation reuses the src instances by muxing in the held value.

Test Plan:
1. Packet-count hysteresis, max=10, HYST_PKTS=2: dst num=10 -> full[3]=1 and full_rise[3] pulses. src num=9 -> stays 1. src num=7 -> full[3]=0.
2. Words criterion, thresh=1000, MAX_PKT=256: left=1000 -> full=1. left=1050 -> stays 1. left=1065 -> full=0. With thresh=0, left=511 -> full=1 (below 2*MAX_PKT).
3. Collision: dst num=10 on q1 and src num=2 on q5 done same cycle (max=10 each) -> q1 set at cycle+1; q5 updated at cycle+2. A following dst done on q1 delays q5 by one cycle and does not lose it.
4. Same queue q2, dst sets full and src clears in the same cycle -> full[2] is 1 for one cycle, then 0.
5. initialize q4 while dst done streams every cycle for 5 cycles -> flags of q4 clear the first idle cycle after the stream; no other queue affected.
6. Assert reset with held src and held init pending -> full=0 and full_rise=0 next cycle; no deferred writes appear after reset deasserts.
